// File: rtl/asteroid_pkg.sv
// Shared types, constants and helpers for the asteroid spawner family.
package asteroid_pkg;

  typedef enum logic [1:0] {IDLE, GAP, SPAWN, FLY} state_t;

  localparam int unsigned NUM_PATTERNS = 6;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [8:0]  X_LIMIT      = 9'd320;
  localparam logic [9:0]  Y_LIMIT      = 10'd480;

  // Fold the 3-bit random value onto the valid trajectory range.
  function automatic logic [2:0] pattern_of(input logic [2:0] r);
    return (r < 3'(NUM_PATTERNS)) ? r : r - 3'(NUM_PATTERNS);
  endfunction

  // Launch gap in ticks, saturating at 255.
  function automatic logic [7:0] gap_of(input logic [7:0] r,
                                        input logic [7:0] min_gap,
                                        input logic [7:0] mask);
    logic [8:0] sum;
    sum = {1'b0, min_gap} + {1'b0, r & mask};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/asteroid_spawner_lfsr16.sv
// 16-bit right-shifting Galois LFSR with load-on-reset seed and enable.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  import asteroid_pkg::*;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed;
    end else if (en) begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/asteroid_spawner.sv
// Launch/retire controller for asteroid_move: random gaps, random trajectory,
// retire on leaving the play field or on clear.
module asteroid_spawner #(
  parameter int unsigned TICK_DIV  = 251250,
  parameter int unsigned MIN_GAP   = 8,
  parameter logic [7:0]  GAP_MASK  = 8'h3F,
  parameter logic [8:0]  X_LIMIT   = asteroid_pkg::X_LIMIT,
  parameter logic [9:0]  Y_LIMIT   = asteroid_pkg::Y_LIMIT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       start,
  input  logic       clear,
  input  logic [8:0] xmovaddr,
  input  logic [9:0] ymovaddr,
  output logic       asteroid_on,
  output logic [2:0] new_count,
  output logic [7:0] spawn_count
);
  import asteroid_pkg::*;

  localparam logic [17:0] TICK_LAST = 18'(TICK_DIV - 1);

  state_t      state, state_next;
  logic [17:0] tick_cnt;
  logic        tick;
  logic [7:0]  gap_cnt, gap_next, gap_load;
  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic        run, retire;
  logic        on_next;
  logic [2:0]  nc_next;
  logic [7:0]  sc_next;

  assign run         = !halt;
  assign tick        = (tick_cnt == TICK_LAST);
  assign retire      = (xmovaddr >= X_LIMIT) || (ymovaddr >= Y_LIMIT) || clear;
  assign gap_load    = gap_of(lfsr[7:0], 8'(MIN_GAP), GAP_MASK);
  // Upper LFSR bits are only consumed by other spawners sharing lfsr16.
  assign lfsr_unused = ^lfsr[15:8];

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Movement tick divider; frozen while halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= 18'd0;
    end else if (run) begin
      tick_cnt <= tick ? 18'd0 : tick_cnt + 18'd1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gap_cnt     <= 8'd0;
      asteroid_on <= 1'b0;
      new_count   <= 3'd0;
      spawn_count <= 8'd0;
    end else if (run) begin
      state       <= state_next;
      gap_cnt     <= gap_next;
      asteroid_on <= on_next;
      new_count   <= nc_next;
      spawn_count <= sc_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = GAP;
      GAP:     if (tick && (gap_cnt == 8'd0)) state_next = SPAWN;
      SPAWN:   state_next = FLY;
      FLY:     if (retire) state_next = GAP;
      default: state_next = IDLE;
    endcase
  end

  // Pattern is latched on entry to SPAWN so it leads asteroid_on by a cycle.
  always_comb begin
    on_next  = (state_next == FLY);
    nc_next  = new_count;
    sc_next  = spawn_count;
    gap_next = gap_cnt;
    if ((state == GAP) && (state_next == SPAWN)) begin
      nc_next = pattern_of(lfsr[2:0]);
      sc_next = spawn_count + 8'd1;
    end
    if ((state != GAP) && (state_next == GAP)) begin
      gap_next = gap_load;
    end else if ((state == GAP) && tick && (gap_cnt != 8'd0)) begin
      gap_next = gap_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_asteroid_spawner.sv
// Scoreboard bench for asteroid_spawner: launch/retire events predicted on a
// timeline of non-halted cycles and checked by an independent monitor.
module tb_asteroid_spawner;

  localparam int          TDIV  = 4;
  localparam int          MGAP  = 2;
  localparam logic [7:0]  GMASK = 8'h00;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          LPER  = 65535;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       halt = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [8:0] xmovaddr = 9'd0;
  logic [9:0] ymovaddr = 10'd0;
  logic       asteroid_on;
  logic [2:0] new_count;
  logic [7:0] spawn_count;

  asteroid_spawner #(
    .TICK_DIV (TDIV),
    .MIN_GAP  (MGAP),
    .GAP_MASK (GMASK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .halt        (halt),
    .start       (start),
    .clear       (clear),
    .xmovaddr    (xmovaddr),
    .ymovaddr    (ymovaddr),
    .asteroid_on (asteroid_on),
    .new_count   (new_count),
    .spawn_count (spawn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         launch;
    int         at;
    logic [2:0] pat;
    logic [7:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int          act = 0;
  bit          rst_q = 1'b1;
  logic [15:0] lseq [0:LPER-1];
  int          model_cnt = 0;
  logic [2:0]  model_pat = 3'd0;
  int          next_rise = 0;
  bit          seen [0:5];

  // act labels each DUT state by the number of non-halted cycles since reset.
  always @(posedge clk) begin
    rst_q <= reset;
    if (reset) act <= 0;
    else if (!halt) act <= act + 1;
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (act %0d)", name, actual, expected, act);
    end
  endtask

  function automatic int gap_len(input logic [15:0] l);
    int g;
    g = MGAP + int'(l[7:0] & GMASK);
    return (g > 255) ? 255 : g;
  endfunction

  // Gap load at cycle n: launch decided on the (gap+1)-th tick after n,
  // pattern visible next cycle, asteroid_on one cycle after that.
  task automatic sched_launch(input int n);
    int ft, t;
    ft = n + 1;
    while (ft % TDIV != TDIV - 1) ft++;
    t = ft + TDIV * gap_len(lseq[n % LPER]);
    model_cnt++;
    model_pat = 3'(int'(lseq[t % LPER][2:0]) % 6);
    sb.push_back('{launch: 1'b1, at: t + 2, pat: model_pat, cnt: 8'(model_cnt)});
    next_rise = t + 2;
  endtask

  task automatic sched_retire(input int k);
    sb.push_back('{launch: 1'b0, at: k + 1, pat: model_pat, cnt: 8'(model_cnt)});
    sched_launch(k);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance to the predicted FLY entry, optionally with ignored start/clear and halts.
  task automatic wait_rise(input bit noisy);
    int b;
    b = 0;
    while (act < next_rise) begin
      start = noisy && ($urandom_range(0, 3) == 0);
      clear = noisy && ($urandom_range(0, 2) == 0);
      halt  = noisy && ($urandom_range(0, 15) == 0);
      cyc();
      b++;
      if (b > 4000) begin
        check("rise_timeout", act, next_rise);
        break;
      end
    end
    start = 1'b0;
    clear = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic fly_and_retire(input int mode);
    int stay;
    stay = $urandom_range(0, 3);
    repeat (stay) begin
      xmovaddr = ($urandom_range(0, 1) == 0) ? 9'd319 : 9'($urandom_range(0, 319));
      ymovaddr = ($urandom_range(0, 1) == 0) ? 10'd479 : 10'($urandom_range(0, 479));
      halt  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 1) == 0);
      cyc();
    end
    halt  = 1'b0;
    start = 1'b0;
    case (mode)
      0:       ymovaddr = 10'd480;
      1:       xmovaddr = 9'd320;
      2:       clear = 1'b1;
      3:       begin xmovaddr = 9'd320; clear = 1'b1; end
      default: begin xmovaddr = 9'h1FF; ymovaddr = 10'h3FF; end
    endcase
    sched_retire(act);
    cyc();
    clear = 1'b0;
    if ($urandom_range(0, 1) == 0) begin
      xmovaddr = 9'd0;
      ymovaddr = 10'd0;
    end
    cyc();
    xmovaddr = 9'd0;
    ymovaddr = 10'd0;
  endtask

  // Monitor: pops an expectation on every asteroid_on edge.
  initial begin : monitor
    bit         prev_on;
    logic [2:0] prev_nc;
    exp_t       e;
    prev_on = 1'b0;
    prev_nc = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_q && (asteroid_on !== prev_on)) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_edge: asteroid_on=%0b with nothing expected (act %0d)", asteroid_on, act);
        end else begin
          e = sb.pop_front();
          check("edge_kind", int'(asteroid_on), int'(e.launch));
          check("edge_time", act, e.at);
          if (asteroid_on) begin
            check("pattern", int'(new_count), int'(e.pat));
            check("pattern_lead", int'(prev_nc), int'(e.pat));
            check("pattern_range", int'(new_count <= 3'd5), 1);
            check("spawn_count", int'(spawn_count), int'(e.cnt));
            if (new_count <= 3'd5) seen[new_count] = 1'b1;
          end else begin
            check("pattern_hold", int'(new_count), int'(e.pat));
          end
        end
      end
      prev_on = asteroid_on;
      prev_nc = new_count;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < LPER; i++) begin
      lseq[i] = v;
      v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    end
    for (int p = 0; p < 6; p++) seen[p] = 1'b0;

    cyc();
    cyc();
    reset = 1'b0;
    check("reset_on", int'(asteroid_on), 0);
    check("reset_nc", int'(new_count), 0);
    check("reset_sc", int'(spawn_count), 0);

    for (int i = 0; i < 100; i++) begin
      cyc();
      check("idle_on", int'(asteroid_on), 0);
      check("idle_sc", int'(spawn_count), 0);
      check("idle_nc", int'(new_count), 0);
    end

    // First launch, then y limit, x limit and clear retires.
    start = 1'b1;
    sched_launch(act);
    cyc();
    start = 1'b0;
    wait_rise(1'b0);
    repeat (3) begin
      ymovaddr = 10'd479;
      xmovaddr = 9'd319;
      cyc();
    end
    ymovaddr = 10'd480;
    sched_retire(act);
    cyc();
    cyc();
    ymovaddr = 10'd0;
    xmovaddr = 9'd0;
    wait_rise(1'b0);
    xmovaddr = 9'd320;
    sched_retire(act);
    cyc();
    xmovaddr = 9'd0;
    wait_rise(1'b0);
    clear = 1'b1;
    sched_retire(act);
    cyc();
    clear = 1'b0;

    // Halt mid-GAP, then halt with clear held mid-FLY.
    halt = 1'b1;
    repeat (50) cyc();
    halt = 1'b0;
    wait_rise(1'b1);
    halt  = 1'b1;
    clear = 1'b1;
    repeat (50) cyc();
    halt = 1'b0;
    sched_retire(act);
    cyc();
    clear = 1'b0;
    wait_rise(1'b1);

    // Reset while flying.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb.delete();
    model_cnt = 0;
    model_pat = 3'd0;
    check("midfly_reset_on", int'(asteroid_on), 0);
    check("midfly_reset_nc", int'(new_count), 0);
    check("midfly_reset_sc", int'(spawn_count), 0);
    cyc();

    // Long randomized run: wraps spawn_count and covers all patterns.
    start = 1'b1;
    sched_launch(act);
    cyc();
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      wait_rise(1'b1);
      fly_and_retire(int'($urandom_range(0, 4)));
    end
    wait_rise(1'b1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    for (int p = 0; p < 6; p++) check("pattern_seen", int'(seen[p]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
